// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_queue
// Description : Instruction prefetch queue. Issues one instruction-memory read
//               at a time, stores {instruction, pc} pairs in a small circular
//               buffer and presents the head entry to the consumer. Supports
//               redirect (flush) with discard of an in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_queue #(
    parameter int                    IWIDTH   = 32,
    parameter int                    PC_WIDTH = 32,
    parameter int                    DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                        q_clk,
    input  logic                        q_rst,
    input  logic                        q_i_ce,
    input  logic                        q_i_stall,
    input  logic                        q_i_flush,
    input  logic [PC_WIDTH-1:0]         q_i_flush_pc,
    output logic                        q_o_mem_req,
    output logic [PC_WIDTH-1:0]         q_o_mem_addr,
    input  logic                        q_i_mem_ack,
    input  logic [IWIDTH-1:0]           q_i_mem_data,
    output logic                        q_o_valid,
    output logic [IWIDTH-1:0]           q_o_instr,
    output logic [PC_WIDTH-1:0]         q_o_pc,
    output logic [$clog2(DEPTH):0]      q_o_count
);

    localparam int                    c_AW      = $clog2(DEPTH);
    localparam int                    c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0]       c_FULL    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]       c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0]       c_PTR_ONE = c_AW'(1);
    localparam logic [PC_WIDTH-1:0]   c_PC_STEP = PC_WIDTH'(4);

    // Entry storage: instruction word and the address it was fetched from.
    logic [IWIDTH-1:0]   r_instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];

    logic [c_AW-1:0]     r_head;
    logic [c_AW-1:0]     r_tail;
    logic [c_CW-1:0]     r_count;
    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_req_addr;
    logic                r_req;
    logic                r_discard;

    logic                w_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic [c_CW-1:0]     w_count_next;
    logic [PC_WIDTH-1:0] w_fetch_pc_next;

    // Handshake decode: acks only count against an outstanding request, and
    // a response is kept only if no discard is pending and no flush is live.
    always_comb begin
        w_ack  = r_req & q_i_mem_ack;
        w_push = w_ack & ~r_discard & ~q_i_flush;
        w_pop  = (r_count != '0) & ~q_i_stall & ~q_i_flush;

        w_count_next = r_count;
        if (q_i_flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + c_CNT_ONE;
                2'b01:   w_count_next = r_count - c_CNT_ONE;
                default: w_count_next = r_count;
            endcase
        end

        w_fetch_pc_next = r_fetch_pc;
        if (q_i_flush) begin
            w_fetch_pc_next = q_i_flush_pc;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + c_PC_STEP;
        end

        // A new request may start in the same edge that retires the old one,
        // but only if the queue will still have room once this cycle settles.
        w_issue = q_i_ce & ~q_i_flush & (~r_req | w_ack) & (w_count_next < c_FULL);
    end

    // Control state: pointers, occupancy, fetch address and request tracking.
    always_ff @(posedge q_clk or posedge q_rst) begin
        if (q_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_req      <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_fetch_pc <= w_fetch_pc_next;

            if (q_i_flush) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
            end

            // Address is captured at issue and held until the ack retires it.
            if (w_issue) begin
                r_req      <= 1'b1;
                r_req_addr <= w_fetch_pc_next;
            end else if (w_ack) begin
                r_req      <= 1'b0;
            end

            // A flush that cannot retire the in-flight request marks its
            // response for disposal; the next ack clears the mark.
            if (q_i_flush & r_req & ~w_ack) begin
                r_discard <= 1'b1;
            end else if (w_ack) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Entry write on accepted response; contents need no reset.
    always_ff @(posedge q_clk) begin
        if (w_push) begin
            r_instr_mem[r_tail] <= q_i_mem_data;
            r_pc_mem[r_tail]    <= r_req_addr;
        end
    end

    assign q_o_mem_req  = r_req;
    assign q_o_mem_addr = r_req_addr;
    assign q_o_valid    = (r_count != '0);
    // Head values are forced to zero while empty so outputs read clean.
    assign q_o_instr    = q_o_valid ? r_instr_mem[r_head] : '0;
    assign q_o_pc       = q_o_valid ? r_pc_mem[r_head]    : '0;
    assign q_o_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_queue
// Description : Self-checking bench for prefetch_queue. A memory responder
//               with programmable latency feeds a scoreboard of expected
//               {pc, instr} pairs that is consumed as the queue pops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        ack;
    logic [31:0] mdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  count;

    int          n_vec;
    int          n_err;

    logic [31:0] sb_pc[$];
    logic [31:0] sb_in[$];
    logic [31:0] seen[$];
    int          mem_lat;
    int          mem_cnt;
    bit          mem_busy;
    bit          drop_flag;
    bit          last_push;
    logic [31:0] mem_cur;
    int          unstable;

    prefetch_queue #(
        .IWIDTH   (32),
        .PC_WIDTH (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .q_clk        (clk),
        .q_rst        (rst),
        .q_i_ce       (ce),
        .q_i_stall    (stall),
        .q_i_flush    (flush),
        .q_i_flush_pc (flush_pc),
        .q_o_mem_req  (mem_req),
        .q_o_mem_addr (mem_addr),
        .q_i_mem_ack  (ack),
        .q_i_mem_data (mdata),
        .q_o_valid    (valid),
        .q_o_instr    (instr),
        .q_o_pc       (pc),
        .q_o_count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Memory responder for one cycle (called at a negedge after the inputs
    // for the coming edge are set). Records requests, drives ack/data and
    // pushes the expected queue entry for every response that is kept.
    task automatic mem_drive();
        last_push = 1'b0;
        if (flush) begin
            sb_pc.delete();
            sb_in.delete();
        end
        ack   = 1'b0;
        mdata = 32'hBAD0_BAD0;
        if (mem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 1;
                mem_cur  = mem_addr;
                seen.push_back(mem_addr);
            end else begin
                mem_cnt++;
                if (mem_addr !== mem_cur) unstable++;
            end
            if (mem_cnt >= mem_lat) begin
                ack      = 1'b1;
                mdata    = mem_word(mem_cur);
                mem_busy = 1'b0;
                if (drop_flag) begin
                    drop_flag = 1'b0;
                end else if (!flush) begin
                    sb_pc.push_back(mem_cur);
                    sb_in.push_back(mem_word(mem_cur));
                    last_push = 1'b1;
                end
            end else if (flush) begin
                drop_flag = 1'b1;
            end
        end else begin
            mem_busy = 1'b0;
        end
    endtask

    task automatic clear_env();
        ce = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        ack = 1'b0; mdata = '0;
        mem_busy = 1'b0; drop_flag = 1'b0; mem_cnt = 0; unstable = 0;
        sb_pc.delete(); sb_in.delete(); seen.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_env();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", mem_req); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid); end
        n_vec++;
        if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", count); end
        rst = 1'b0; ce = 1'b1; mem_lat = 1;
        mem_drive();
        n_vec++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL early_req got=%b want=0", mem_req); end
        @(negedge clk);
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            begin n_err++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] e_pc, e_in;
        int pops = 0;
        do_reset();
        ce = 1'b1; mem_lat = 1;
        for (int i = 0; i < 14; i++) begin
            mem_drive();
            if (valid && !stall && !flush) begin
                n_vec++; pops++;
                if (sb_pc.size() == 0) begin n_err++; $display("FAIL stream_pop got pc=%h want none", pc); end
                else begin
                    e_pc = sb_pc.pop_front(); e_in = sb_in.pop_front();
                    if (pc !== e_pc || instr !== e_in)
                        begin n_err++; $display("FAIL stream_pop got pc=%h instr=%h want pc=%h instr=%h", pc, instr, e_pc, e_in); end
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (seen.size() <= i || seen[i] !== 32'(4 * i))
                begin n_err++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, (seen.size() > i) ? seen[i] : 32'hx, 32'(4 * i)); end
        end
        n_vec++;
        if (pops < 8 || unstable != 0) begin n_err++; $display("FAIL stream_flow got pops=%0d unstable=%0d want pops>=8 unstable=0", pops, unstable); end
    endtask

    task automatic test_full_stall();
        logic [31:0] e_pc, e_in;
        int pops = 0;
        do_reset();
        ce = 1'b1; stall = 1'b1; mem_lat = 1;
        for (int i = 0; i < 12; i++) begin
            mem_drive();
            @(negedge clk);
        end
        n_vec++;
        if (count !== 3'd4 || mem_req !== 1'b0)
            begin n_err++; $display("FAIL full_hold got count=%0d req=%b want count=4 req=0", count, mem_req); end
        n_vec++;
        if (seen.size() != 4 || seen[seen.size()-1] !== 32'hC)
            begin n_err++; $display("FAIL full_addrs got n=%0d want n=4 last=0000000c", seen.size()); end
        stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_drive();
            if (valid && !stall && !flush) begin
                n_vec++; pops++;
                if (sb_pc.size() == 0) begin n_err++; $display("FAIL drain_pop got pc=%h want none", pc); end
                else begin
                    e_pc = sb_pc.pop_front(); e_in = sb_in.pop_front();
                    if (pc !== e_pc || instr !== e_in)
                        begin n_err++; $display("FAIL drain_pop got pc=%h instr=%h want pc=%h instr=%h", pc, instr, e_pc, e_in); end
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (seen.size() < 5 || seen[4] !== 32'h10 || pops < 4)
            begin n_err++; $display("FAIL resume_addr got n=%0d pops=%0d want addr[4]=00000010 pops>=4", seen.size(), pops); end
    endtask

    task automatic test_flush_discard();
        logic [31:0] e_pc, e_in;
        bit found = 1'b0;
        int pops = 0;
        int idx = -1;
        do_reset();
        ce = 1'b1; mem_lat = 4;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_req && mem_addr == 32'h10) found = 1'b1;
            else begin mem_drive(); @(negedge clk); end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL flush_setup got no req to 00000010 want req"); end
        flush = 1'b1; flush_pc = 32'h100;
        mem_drive();
        @(negedge clk);
        flush = 1'b0;
        n_vec++;
        if (valid !== 1'b0 || count !== 3'd0)
            begin n_err++; $display("FAIL flush_clear got valid=%b count=%0d want 0/0", valid, count); end
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10)
            begin n_err++; $display("FAIL flush_hold got req=%b addr=%h want req=1 addr=00000010", mem_req, mem_addr); end
        for (int i = 0; i < 24; i++) begin
            mem_drive();
            if (valid && !stall && !flush) begin
                n_vec++; pops++;
                if (sb_pc.size() == 0) begin n_err++; $display("FAIL flush_pop got pc=%h want none", pc); end
                else begin
                    e_pc = sb_pc.pop_front(); e_in = sb_in.pop_front();
                    if (pc !== e_pc || instr !== e_in)
                        begin n_err++; $display("FAIL flush_pop got pc=%h instr=%h want pc=%h instr=%h", pc, instr, e_pc, e_in); end
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < seen.size(); i++) if (seen[i] == 32'h10 && idx < 0) idx = i;
        n_vec++;
        if (idx < 0 || idx + 1 >= seen.size() || seen[idx+1] !== 32'h100 || pops == 0 || unstable != 0)
            begin n_err++; $display("FAIL flush_redirect got idx=%0d n=%0d pops=%0d unstable=%0d want next addr 00000100", idx, seen.size(), pops, unstable); end
    endtask

    task automatic test_wrap();
        logic [31:0] e_pc, e_in;
        logic [2:0] prev;
        bit both;
        int pops = 0;
        do_reset();
        ce = 1'b1; stall = 1'b1; mem_lat = 1;
        for (int i = 0; i < 10; i++) begin mem_drive(); @(negedge clk); end
        n_vec++;
        if (count !== 3'd4) begin n_err++; $display("FAIL wrap_fill got count=%0d want 4", count); end
        stall = 1'b0;
        for (int i = 0; i < 24; i++) begin
            mem_drive();
            both = 1'b0;
            if (valid && !stall && !flush) begin
                n_vec++; pops++;
                both = last_push;
                if (sb_pc.size() == 0) begin n_err++; $display("FAIL wrap_pop got pc=%h want none", pc); end
                else begin
                    e_pc = sb_pc.pop_front(); e_in = sb_in.pop_front();
                    if (pc !== e_pc || instr !== e_in)
                        begin n_err++; $display("FAIL wrap_pop got pc=%h instr=%h want pc=%h instr=%h", pc, instr, e_pc, e_in); end
                end
            end
            prev = count;
            @(negedge clk);
            if (both) begin
                n_vec++;
                if (count !== prev) begin n_err++; $display("FAIL wrap_count got=%0d want=%0d", count, prev); end
            end
        end
        n_vec++;
        if (pops < 16) begin n_err++; $display("FAIL wrap_pops got=%0d want>=16", pops); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        ce = 1'b1; stall = 1'b1; mem_lat = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            if (count == 3'd2 && mem_req) found = 1'b1;
            else begin mem_drive(); @(negedge clk); end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL midrst_setup got count=%0d req=%b want 2/1", count, mem_req); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0)
            begin n_err++; $display("FAIL midrst_req got req=%b addr=%h want 0/00000000", mem_req, mem_addr); end
        n_vec++;
        if (valid !== 1'b0 || count !== 3'd0)
            begin n_err++; $display("FAIL midrst_queue got valid=%b count=%0d want 0/0", valid, count); end
        n_vec++;
        if (instr !== 32'h0 || pc !== 32'h0)
            begin n_err++; $display("FAIL midrst_head got instr=%h pc=%h want 0/0", instr, pc); end
        mem_busy = 1'b0; drop_flag = 1'b0; ack = 1'b0;
        sb_pc.delete(); sb_in.delete(); seen.delete();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; mem_lat = 1;
        for (int i = 0; i < 4; i++) begin mem_drive(); @(negedge clk); end
        n_vec++;
        if (seen.size() == 0 || seen[0] !== 32'h0)
            begin n_err++; $display("FAIL midrst_first got n=%0d want first addr 00000000", seen.size()); end
    endtask

    task automatic test_ce_off();
        logic [31:0] e_pc, e_in;
        do_reset();
        ce = 1'b1; stall = 1'b1; mem_lat = 3;
        mem_drive();
        @(negedge clk);
        ce = 1'b0;
        for (int i = 0; i < 8; i++) begin mem_drive(); @(negedge clk); end
        n_vec++;
        if (count !== 3'd1 || valid !== 1'b1)
            begin n_err++; $display("FAIL ceoff_enqueue got count=%0d valid=%b want 1/1", count, valid); end
        n_vec++;
        if (mem_req !== 1'b0 || seen.size() != 1)
            begin n_err++; $display("FAIL ceoff_noreq got req=%b n=%0d want 0/1", mem_req, seen.size()); end
        ce = 1'b1; stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_drive();
            if (valid && !stall && !flush) begin
                n_vec++;
                if (sb_pc.size() == 0) begin n_err++; $display("FAIL ceoff_pop got pc=%h want none", pc); end
                else begin
                    e_pc = sb_pc.pop_front(); e_in = sb_in.pop_front();
                    if (pc !== e_pc || instr !== e_in)
                        begin n_err++; $display("FAIL ceoff_pop got pc=%h instr=%h want pc=%h instr=%h", pc, instr, e_pc, e_in); end
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (seen.size() < 2 || seen[1] !== 32'h4)
            begin n_err++; $display("FAIL ceoff_resume got n=%0d want addr[1]=00000004", seen.size()); end
    endtask

    task automatic test_flush_ack();
        logic [31:0] e_pc, e_in;
        logic [31:0] first_pc = 32'hFFFF_FFFF;
        bit got300 = 1'b0;
        bit got400 = 1'b0;
        do_reset();
        ce = 1'b1; stall = 1'b1; mem_lat = 1;
        mem_drive();
        @(negedge clk);
        flush = 1'b1; flush_pc = 32'h200;
        mem_drive();
        @(negedge clk);
        flush = 1'b0;
        n_vec++;
        if (valid !== 1'b0 || count !== 3'd0)
            begin n_err++; $display("FAIL flushack_drop got valid=%b count=%0d want 0/0", valid, count); end
        for (int i = 0; i < 3; i++) begin mem_drive(); @(negedge clk); end
        n_vec++;
        if (seen.size() < 2 || seen[1] !== 32'h200)
            begin n_err++; $display("FAIL flushack_next got n=%0d want addr[1]=00000200", seen.size()); end
        mem_lat = 3;
        flush = 1'b1; flush_pc = 32'h300;
        mem_drive();
        @(negedge clk);
        flush_pc = 32'h400;
        mem_drive();
        @(negedge clk);
        flush = 1'b0; stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_drive();
            if (valid && !stall && !flush) begin
                n_vec++;
                if (first_pc === 32'hFFFF_FFFF) first_pc = pc;
                if (sb_pc.size() == 0) begin n_err++; $display("FAIL reflush_pop got pc=%h want none", pc); end
                else begin
                    e_pc = sb_pc.pop_front(); e_in = sb_in.pop_front();
                    if (pc !== e_pc || instr !== e_in)
                        begin n_err++; $display("FAIL reflush_pop got pc=%h instr=%h want pc=%h instr=%h", pc, instr, e_pc, e_in); end
                end
            end
            @(negedge clk);
        end
        foreach (seen[i]) begin
            if (seen[i] == 32'h300) got300 = 1'b1;
            if (seen[i] == 32'h400) got400 = 1'b1;
        end
        n_vec++;
        if (got300 || !got400 || first_pc !== 32'h400)
            begin n_err++; $display("FAIL reflush_last got fetched300=%b fetched400=%b first_pc=%h want 0/1/00000400", got300, got400, first_pc); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        mem_lat = 1;
        clear_env();
        test_reset();
        test_stream();
        test_full_stall();
        test_flush_discard();
        test_wrap();
        test_reset_mid();
        test_ce_off();
        test_flush_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
